hazard_ctrl: RTL and testbench

- Hazard and forwarding controller for the 5-stage RV32 pipeline.
- Consumes the E-stage operand and control fields published by the ID/EX register, plus M/W write-back info and memory handshake status.
- Produces the stall and flush controls that drive the F/D, ID/EX, EX/MEM and MEM/WB registers, and the forwarding selects for the EX operand muxes.
- Tracks load-use bubbles and memory wait states with a small FSM and a wait watchdog.

---
 rtl/hazard_ctrl.sv | 100 ++++++++++
 tb/tb_hazard_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding control for the 5-stage RV32 pipeline.
// Define HAZARD_PERF_EN to build the load-use/branch/memory-wait event counters.
module hazard_ctrl #(
  parameter int TIMEOUT_CYC = 255,
  parameter int WAIT_CNT_W  = 8,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        rs1_D,
  input  logic [4:0]        rs2_D,
  input  logic [4:0]        rs1_E,
  input  logic [4:0]        rs2_E,
  input  logic [4:0]        rd_E,
  input  logic [1:0]        wb_ctrl_E,
  input  logic              we_reg_E,
  input  logic [4:0]        rd_M,
  input  logic [4:0]        rd_W,
  input  logic              we_reg_M,
  input  logic              we_reg_W,
  input  logic              branch_taken_E,
  input  logic              mem_req_M,
  input  logic              mem_ready_M,
  output logic              stall_F,
  output logic              stall_D,
  output logic              stall_E,
  output logic              stall_M,
  output logic              flush_D,
  output logic              flush_E,
  output logic              flush_W,
  output logic [1:0]        fwd_a_E,
  output logic [1:0]        fwd_b_E,
  output logic              mem_timeout,
  output logic [PERF_W-1:0] perf_lu,
  output logic [PERF_W-1:0] perf_br,
  output logic [PERF_W-1:0] perf_mw
);
  typedef enum logic [1:0] {RUN, LU_BUBBLE, MEM_WAIT} state_t;
  state_t                r_state;
  logic [WAIT_CNT_W-1:0] r_wait_cnt;
  logic                  r_timeout;
  logic                  w_load_use, w_mem_wait, w_r1, w_r2, w_r3;
  logic [WAIT_CNT_W-1:0] w_cnt_nxt;
  assign w_load_use = wb_ctrl_E == 2'b01 && we_reg_E && rd_E != 5'd0 &&
                      (rd_E == rs1_D || rd_E == rs2_D);
  assign w_mem_wait = mem_req_M && !mem_ready_M;
  assign w_r1 = w_mem_wait;
  assign w_r2 = !w_mem_wait && branch_taken_E;
  assign w_r3 = !w_mem_wait && !branch_taken_E && w_load_use && r_state != LU_BUBBLE;
  assign stall_F = !rst && (w_r1 || w_r3);
  assign stall_D = !rst && (w_r1 || w_r3);
  assign stall_E = !rst && w_r1;
  assign stall_M = !rst && w_r1;
  assign flush_D = rst || w_r2;
  assign flush_E = rst || w_r2 || w_r3;
  assign flush_W = rst || w_r1;
  // M result is newer than W, so it wins; x0 never forwards
  always_comb begin
    fwd_a_E = rst ? 2'b00 :
              (we_reg_M && rd_M != 5'd0 && rd_M == rs1_E) ? 2'b10 :
              (we_reg_W && rd_W != 5'd0 && rd_W == rs1_E) ? 2'b01 : 2'b00;
    fwd_b_E = rst ? 2'b00 :
              (we_reg_M && rd_M != 5'd0 && rd_M == rs2_E) ? 2'b10 :
              (we_reg_W && rd_W != 5'd0 && rd_W == rs2_E) ? 2'b01 : 2'b00;
  end
  assign w_cnt_nxt = !w_mem_wait ? '0 :
                     (r_wait_cnt == '1) ? r_wait_cnt : r_wait_cnt + 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_mem_wait ? MEM_WAIT :
                    (w_r3 && r_state == RUN) ? LU_BUBBLE : RUN;
      r_wait_cnt <= w_cnt_nxt;
      r_timeout  <= r_timeout || (w_mem_wait && w_cnt_nxt == WAIT_CNT_W'(TIMEOUT_CYC));
    end
  assign mem_timeout = r_timeout;
`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] r_perf_lu, r_perf_br, r_perf_mw;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_perf_lu <= '0;
      r_perf_br <= '0;
      r_perf_mw <= '0;
    end else begin
      if (w_r3 && r_perf_lu != '1) r_perf_lu <= r_perf_lu + 1'b1;
      if (w_r2 && r_perf_br != '1) r_perf_br <= r_perf_br + 1'b1;
      if (w_r1 && r_perf_mw != '1) r_perf_mw <= r_perf_mw + 1'b1;
    end
  assign perf_lu = r_perf_lu;
  assign perf_br = r_perf_br;
  assign perf_mw = r_perf_mw;
`else
  assign perf_lu = '0;
  assign perf_br = '0;
  assign perf_mw = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors for hazard_ctrl with TIMEOUT_CYC=4.
module tb_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic [1:0]  wb_ctrl_E;
  logic        we_reg_E, we_reg_M, we_reg_W, branch_taken_E, mem_req_M, mem_ready_M;
  logic        stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W, mem_timeout;
  logic [1:0]  fwd_a_E, fwd_b_E;
  logic [31:0] perf_lu, perf_br, perf_mw;
  logic [6:0]  ctl;
  int          n_vec = 0;
  int          n_err = 0;
  hazard_ctrl #(.TIMEOUT_CYC(4), .WAIT_CNT_W(8), .PERF_W(32)) dut (
    .clk(clk), .rst(rst), .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
    .rd_E(rd_E), .wb_ctrl_E(wb_ctrl_E), .we_reg_E(we_reg_E), .rd_M(rd_M), .rd_W(rd_W),
    .we_reg_M(we_reg_M), .we_reg_W(we_reg_W), .branch_taken_E(branch_taken_E),
    .mem_req_M(mem_req_M), .mem_ready_M(mem_ready_M), .stall_F(stall_F), .stall_D(stall_D),
    .stall_E(stall_E), .stall_M(stall_M), .flush_D(flush_D), .flush_E(flush_E),
    .flush_W(flush_W), .fwd_a_E(fwd_a_E), .fwd_b_E(fwd_b_E), .mem_timeout(mem_timeout),
    .perf_lu(perf_lu), .perf_br(perf_br), .perf_mw(perf_mw));
  always #5 clk = ~clk;
  // {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W}
  assign ctl = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] pe(input int v);
`ifdef HAZARD_PERF_EN
    return 32'(v);
`else
    return 32'(v - v);
`endif
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    {rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W} = '0;
    {wb_ctrl_E, we_reg_E, we_reg_M, we_reg_W, branch_taken_E, mem_req_M, mem_ready_M} = '0;
  endtask
  task automatic lu_on;
    wb_ctrl_E = 2'b01; rd_E = 5'd5; we_reg_E = 1'b1; rs1_D = 5'd5;
  endtask
  initial begin
    idle();
    rst = 1'b1;
    rd_M = 5'd3; we_reg_M = 1'b1; rs1_E = 5'd3;
    #2;
    check("rst_ctl", 32'(ctl), 32'b0000111);
    check("rst_fwd", 32'(fwd_a_E), 32'd0);
    check("rst_tmo", 32'(mem_timeout), 32'd0);
    check("rst_plu", perf_lu, 32'd0);
    tick();
    rst = 1'b0;
    idle();
    #1 check("idle_ctl", 32'(ctl), 32'd0);
    lu_on();
    #1 check("lu_stall", 32'(ctl), 32'b1100010);
    tick();
    check("lu_bubble_only1", 32'(ctl), 32'd0);
    check("lu_perf", perf_lu, pe(1));
    tick();
    check("lu_rerun", 32'(ctl), 32'b1100010);
    idle();
    #1 check("lu_clear", 32'(ctl), 32'd0);
    tick();
    rd_M = 5'd7; rd_W = 5'd7; we_reg_M = 1'b1; we_reg_W = 1'b1; rs1_E = 5'd7; rs2_E = 5'd0;
    #1 check("fwd_a_M", 32'(fwd_a_E), 32'd2);
    check("fwd_b_none", 32'(fwd_b_E), 32'd0);
    we_reg_M = 1'b0;
    #1 check("fwd_a_W", 32'(fwd_a_E), 32'd1);
    rs2_E = 5'd7;
    #1 check("fwd_b_W", 32'(fwd_b_E), 32'd1);
    we_reg_M = 1'b1; rs2_E = 5'd8; rd_M = 5'd8;
    #1 check("fwd_b_M", 32'(fwd_b_E), 32'd2);
    rd_M = 5'd0; rd_W = 5'd0; rs1_E = 5'd0; rs2_E = 5'd0;
    #1 check("fwd_x0", 32'({fwd_a_E, fwd_b_E}), 32'd0);
    idle();
    lu_on();
    branch_taken_E = 1'b1;
    #1 check("br_beats_lu", 32'(ctl), 32'b0000110);
    tick();
    check("br_perf", perf_br, pe(1));
    branch_taken_E = 1'b0;
    #1 check("br_state_run", 32'(ctl), 32'b1100010);
    tick();
    check("lu_perf2", perf_lu, pe(2));
    idle();
    #1 check("br_clear", 32'(ctl), 32'd0);
    tick();
    mem_req_M = 1'b1; branch_taken_E = 1'b1;
    #1 check("mw_c1", 32'(ctl), 32'b1111001);
    tick();
    check("mw_c2", 32'(ctl), 32'b1111001);
    tick();
    check("mw_c3", 32'(ctl), 32'b1111001);
    tick();
    mem_ready_M = 1'b1;
    #1 check("mw_release_br", 32'(ctl), 32'b0000110);
    check("mw_no_tmo", 32'(mem_timeout), 32'd0);
    tick();
    idle();
    #1 check("mw_exit", 32'(ctl), 32'd0);
    check("mw_perf", perf_mw, pe(3));
    check("br_perf2", perf_br, pe(2));
    mem_req_M = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 3) check("wd_edge3", 32'(mem_timeout), 32'd0);
      if (i == 4) check("wd_edge4", 32'(mem_timeout), 32'd1);
    end
    mem_ready_M = 1'b1;
    tick();
    check("wd_sticky", 32'(mem_timeout), 32'd1);
    check("wd_no_stall", 32'(ctl), 32'd0);
    mem_ready_M = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1 check("arst_ctl", 32'(ctl), 32'b0000111);
    check("arst_tmo", 32'(mem_timeout), 32'd0);
    check("arst_perf", perf_mw | perf_lu | perf_br, 32'd0);
    tick();
    rst = 1'b0;
    idle();
    #1 check("post_rst_ctl", 32'(ctl), 32'd0);
    check("post_rst_tmo", 32'(mem_timeout), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
